subleq_loader: RTL and testbench

Boot-time program loader for the URISC/SUBLEQ processor. It accepts a length-prefixed, checksummed stream of words over a valid/ready interface and writes them into the processor's unified RAM from address 0 upward. It holds the processor in reset until a load completes with a good checksum. It sits between the host/bench stimulus and the RAM write port, on the processor's clock.

---
 rtl/subleq_loader.sv | 122 ++++++++++++
 tb/tb_subleq_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_loader.sv
// Boot-time program loader for the SUBLEQ processor: accepts a length-prefixed,
// checksummed word stream and writes it into RAM from address 0, releasing cpu_reset on success.
module subleq_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned MAX_LEN = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  xfer;

  assign in_ready  = (state_q == S_LEN) || (state_q == S_LOAD) || (state_q == S_CHECK);
  assign busy      = in_ready;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  assign cpu_reset = (state_q != S_DONE);
  assign xfer      = in_valid && in_ready;

  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        if (xfer) begin
          len_d = in_data[ADDR_WIDTH:0];
          cnt_d = '0;
          sum_d = '0;
          if (in_data == '0)                state_d = S_CHECK;
          else if (32'(in_data) > MAX_LEN)  state_d = S_ERR;
          else                              state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = in_data;
          sum_d   = sum_q + in_data;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == len_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) state_d = (in_data == sum_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_subleq_loader.sv
// Directed self-checking bench for subleq_loader; a behavioural RAM captures the write port.
module tb_subleq_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int base;
  logic [15:0] mem [256];

  subleq_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we === 1'b1) begin
      mem[ram_addr] <= ram_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic s);
    in_valid = v;
    in_data  = d;
    start    = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic pulse_start();
    step(1'b0, 16'h0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check({tag, "_ram_we"},    32'(ram_we),    32'd0);
    check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
    check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_error"},     32'(error),     32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check_reset_outputs("rst");
    reset = 1'b0;
    step(1'b0, 16'h0, 1'b0);
    check("idle_busy", 32'(busy), 32'd0);

    // Nominal load
    base = wr_cnt;
    pulse_start();
    check("nom_len_busy",  32'(busy),      32'd1);
    check("nom_len_ready", 32'(in_ready),  32'd1);
    check("nom_len_cpurst", 32'(cpu_reset), 32'd1);
    send(16'd3);
    check("nom_after_len_we", 32'(ram_we), 32'd0);
    send(16'h0009);
    check("nom_w0_we", 32'(ram_we), 32'd1);
    check("nom_w0_addr", 32'(ram_addr), 32'd0);
    check("nom_w0_data", 32'(ram_wdata), 32'h9);
    send(16'h000A);
    check("nom_w1_we", 32'(ram_we), 32'd1);
    check("nom_w1_addr", 32'(ram_addr), 32'd1);
    check("nom_w1_data", 32'(ram_wdata), 32'hA);
    send(16'h0003);
    check("nom_w2_we", 32'(ram_we), 32'd1);
    check("nom_w2_addr", 32'(ram_addr), 32'd2);
    check("nom_w2_data", 32'(ram_wdata), 32'h3);
    check("nom_check_busy", 32'(busy), 32'd1);
    send(16'h0016);
    check("nom_done", 32'(done), 32'd1);
    check("nom_cpurst", 32'(cpu_reset), 32'd0);
    check("nom_busy", 32'(busy), 32'd0);
    check("nom_post_we", 32'(ram_we), 32'd0);
    step(1'b0, 16'h0, 1'b0);
    check("nom_wr_count", 32'(wr_cnt - base), 32'd3);
    check("nom_ram2", 32'(mem[2]), 32'h3);

    // Bad checksum from DONE, then recovery
    base = wr_cnt;
    pulse_start();
    check("bad_restart_cpurst", 32'(cpu_reset), 32'd1);
    check("bad_restart_busy", 32'(busy), 32'd1);
    send(16'd3); send(16'h0009); send(16'h000A); send(16'h0003);
    send(16'h0017);
    check("bad_error", 32'(error), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_cpurst", 32'(cpu_reset), 32'd1);
    step(1'b0, 16'h0, 1'b0);
    check("bad_wr_count", 32'(wr_cnt - base), 32'd3);
    check("bad_ram1", 32'(mem[1]), 32'hA);
    pulse_start();
    check("bad_restart_err", 32'(error), 32'd0);
    send(16'd3); send(16'h0009); send(16'h000A); send(16'h0003);
    send(16'h0016);
    check("recover_done", 32'(done), 32'd1);

    // Throttled source with a wrapping sum
    pulse_start();
    base = wr_cnt;
    send(16'd2);
    step(1'b0, 16'h0, 1'b0);
    send(16'hFFFF);
    step(1'b0, 16'h0, 1'b0);
    check("thr_gap_we", 32'(ram_we), 32'd0);
    send(16'h0002);
    check("thr_w1_addr", 32'(ram_addr), 32'd1);
    step(1'b0, 16'h0, 1'b0);
    send(16'h0001);
    check("thr_done", 32'(done), 32'd1);
    step(1'b0, 16'h0, 1'b0);
    check("thr_wr_count", 32'(wr_cnt - base), 32'd2);
    check("thr_ram0", 32'(mem[0]), 32'hFFFF);
    check("thr_ram1", 32'(mem[1]), 32'h0002);

    // N = 0
    pulse_start();
    base = wr_cnt;
    send(16'd0);
    check("n0_check_busy", 32'(busy), 32'd1);
    send(16'h0000);
    check("n0_done", 32'(done), 32'd1);
    step(1'b0, 16'h0, 1'b0);
    check("n0_wr_count", 32'(wr_cnt - base), 32'd0);

    // N = 256 fills the whole RAM; sum of 0..255 is 0x7F80
    pulse_start();
    base = wr_cnt;
    send(16'd256);
    for (int i = 0; i < 256; i++) send(16'(i));
    check("n256_last_we", 32'(ram_we), 32'd1);
    check("n256_last_addr", 32'(ram_addr), 32'hFF);
    send(16'h7F80);
    check("n256_done", 32'(done), 32'd1);
    step(1'b0, 16'h0, 1'b0);
    check("n256_wr_count", 32'(wr_cnt - base), 32'd256);
    check("n256_ram255", 32'(mem[255]), 32'hFF);
    check("n256_ram0", 32'(mem[0]), 32'h0);

    // N = 257 is rejected immediately
    pulse_start();
    base = wr_cnt;
    send(16'd257);
    check("n257_error", 32'(error), 32'd1);
    check("n257_ready", 32'(in_ready), 32'd0);
    send(16'h1234);
    step(1'b0, 16'h0, 1'b0);
    check("n257_wr_count", 32'(wr_cnt - base), 32'd0);

    // Ignored start during LOAD, then reset mid-load
    pulse_start();
    base = wr_cnt;
    send(16'd5);
    send(16'h0011);
    pulse_start();
    check("ign_start_busy", 32'(busy), 32'd1);
    check("ign_start_ready", 32'(in_ready), 32'd1);
    send(16'h0022);
    check("ign_start_addr", 32'(ram_addr), 32'd1);
    check("ign_start_data", 32'(ram_wdata), 32'h22);
    reset = 1'b1;
    send(16'h0033);
    check_reset_outputs("midrst");
    reset = 1'b0;
    send(16'h0044);
    send(16'h0055);
    check("midrst_idle_busy", 32'(busy), 32'd0);
    check("midrst_cpurst", 32'(cpu_reset), 32'd1);
    check("midrst_wr_count", 32'(wr_cnt - base), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
